// File: rtl/led_fader_pkg.sv
// Shared types and constants for the LED fader: FSM state encoding,
// PWM/level limits and the gamma mapping helper.
package led_fader_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } fade_state_e;

    localparam logic [7:0] PWM_MAX   = 8'd254;
    localparam logic [7:0] LEVEL_MAX = 8'd255;

    // Approximate square law: 0->0, 128->64, 255->255.
    function automatic logic [7:0] gamma_map(input logic [7:0] lvl);
        logic [15:0] prod;
        prod = ({8'd0, lvl} + 16'd1) * {8'd0, lvl};
        return prod[15:8];
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// PWM generator with a 255-cycle period. The duty value is sampled only at
// the end of a period, so a changing duty never produces a truncated pulse.
module led_pwm_gen
    import led_fader_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_duty,
    output logic       o_lit
);

    logic [7:0] r_pwm_cnt;
    logic [7:0] r_duty;

    // Period counter 0..PWM_MAX, with duty latched on the last count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm_cnt <= 8'd0;
            r_duty    <= 8'd0;
        end else if (r_pwm_cnt == PWM_MAX) begin
            r_pwm_cnt <= 8'd0;
            r_duty    <= i_duty;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_duty    <= r_duty;
        end
    end

    // Duty 255 exceeds every count, so it is lit for the whole period.
    assign o_lit = (r_pwm_cnt < r_duty);

endmodule

// File: rtl/led_fader.sv
// PWM LED fader: ramps brightness up/down following the blink request.
// Optional build macro LED_FADER_GAMMA_EN applies a square-law duty map.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int         CLK_HZ   = 50000000,
    parameter int         STEP_HZ  = 1000,
    parameter logic [7:0] LED_MASK = 8'h01
) (
    input  logic       CLK_50,
    input  logic       RST_N,
    input  logic       blink_in,
    output logic [7:0] LED,
    output logic [7:0] level,
    output logic       busy
);

    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [PW-1:0] r_presc;
    logic          w_step_tick;
    fade_state_e   r_state;
    fade_state_e   w_state_next;
    logic [7:0]    r_level;
    logic [7:0]    w_level_next;
    logic          r_busy;
    logic          w_busy_next;
    logic [7:0]    w_duty;
    logic          w_lit;
    logic [7:0]    r_led;

    // Two-flop synchroniser for the untimed blink request.
    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= blink_in;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running step prescaler.
    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_presc <= '0;
        end else if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_step_tick = (r_presc == PRESC_MAX);

    // Next state / level; a direction change takes priority over a step.
    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        case (r_state)
            OFF: begin
                w_level_next = 8'd0;
                if (r_sync2) w_state_next = UP;
                else         w_state_next = OFF;
            end
            UP: begin
                if (!r_sync2) begin
                    w_state_next = DOWN;
                end else if (w_step_tick) begin
                    if (r_level != LEVEL_MAX) w_level_next = r_level + 8'd1;
                    else                      w_level_next = r_level;
                    if (w_level_next == LEVEL_MAX) w_state_next = ON;
                    else                           w_state_next = UP;
                end else begin
                    w_state_next = UP;
                end
            end
            ON: begin
                w_level_next = LEVEL_MAX;
                if (!r_sync2) w_state_next = DOWN;
                else          w_state_next = ON;
            end
            DOWN: begin
                if (r_sync2) begin
                    w_state_next = UP;
                end else if (w_step_tick) begin
                    if (r_level != 8'd0) w_level_next = r_level - 8'd1;
                    else                 w_level_next = r_level;
                    if (w_level_next == 8'd0) w_state_next = OFF;
                    else                      w_state_next = DOWN;
                end else begin
                    w_state_next = DOWN;
                end
            end
            default: begin
                w_state_next = OFF;
                w_level_next = 8'd0;
            end
        endcase
    end

    assign w_busy_next = (w_state_next == UP) || (w_state_next == DOWN);

    // FSM state, level and busy registers.
    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= OFF;
            r_level <= 8'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_level <= w_level_next;
            r_busy  <= w_busy_next;
        end
    end

`ifdef LED_FADER_GAMMA_EN
    assign w_duty = gamma_map(r_level);
`else
    assign w_duty = r_level;
`endif

    led_pwm_gen u_pwm (
        .i_clk   (CLK_50),
        .i_rst_n (RST_N),
        .i_duty  (w_duty),
        .o_lit   (w_lit)
    );

    // Active-low LED drive; unmasked LEDs stay dark.
    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_led <= 8'hFF;
        end else begin
            r_led <= ~(LED_MASK & {8{w_lit}});
        end
    end

    assign LED   = r_led;
    assign level = r_level;
    assign busy  = r_busy;

endmodule
